// File: rtl/count_mon_y_if.sv
// Calendar bus between the month/year/century counter and its neighbours:
// strobes coming in, calendar context going back out.
interface count_mon_y_if;
  logic       pulse_mon;
  logic       btn_mode;
  logic       btn_inc;
  logic [3:0] cnt_mon;
  logic [6:0] cnt_y;
  logic [6:0] cnt_c;
  logic       leap;
  logic [4:0] dim;
  logic [1:0] set_state;
  logic       pulse_c;

  // Master side: the day counter / button logic driving the strobes
  modport master (
    output pulse_mon, btn_mode, btn_inc,
    input  cnt_mon, cnt_y, cnt_c, leap, dim, set_state, pulse_c
  );

  // Slave side: the month/year/century counter itself
  modport slave (
    input  pulse_mon, btn_mode, btn_inc,
    output cnt_mon, cnt_y, cnt_c, leap, dim, set_state, pulse_c
  );
endinterface

// File: rtl/count_mon_y.sv
// Month / year-in-century / century counter for the century clock.
// Advances on the day counter's month-rollover strobe while running, and
// owns the set-mode FSM that lets the user adjust each field by hand.
module count_mon_y #(
  parameter int RST_MON = 1,
  parameter int RST_Y   = 0,
  parameter int RST_C   = 20,
  parameter int Y_MAX   = 99,
  parameter int C_MAX   = 99
) (
  input  logic         clk,
  input  logic         rst_n,
  count_mon_y_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_MON = 2'd1,
    SET_Y   = 2'd2,
    SET_C   = 2'd3
  } state_t;

  localparam logic [3:0] RST_MON_V = 4'(RST_MON);
  localparam logic [6:0] RST_Y_V   = 7'(RST_Y);
  localparam logic [6:0] RST_C_V   = 7'(RST_C);
  localparam logic [6:0] Y_MAX_V   = 7'(Y_MAX);
  localparam logic [6:0] C_MAX_V   = 7'(C_MAX);

  state_t     state_q, state_d;
  logic [3:0] mon_q, mon_d;
  logic [6:0] y_q, y_d;
  logic [6:0] c_q, c_d;
  logic       pc_q, pc_d;
  logic       inc_ok;

  // A mode press in the same cycle as an increment press swallows the increment
  assign inc_ok = bus.btn_inc && !bus.btn_mode;

  // Set-mode FSM next state: cycles through the fields on each mode press
  always_comb begin
    state_d = state_q;
    if (bus.btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_MON;
        SET_MON: state_d = SET_Y;
        SET_Y:   state_d = SET_C;
        SET_C:   state_d = RUN;
      endcase
    end
  end

  // Counter next values: full carry chain when running, single-field wrap when setting
  always_comb begin
    mon_d = mon_q;
    y_d   = y_q;
    c_d   = c_q;
    pc_d  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.pulse_mon) begin
          if (mon_q >= 4'd12) begin
            mon_d = 4'd1;
            if (y_q >= Y_MAX_V) begin
              y_d = 7'd0;
              if (c_q >= C_MAX_V) begin
                c_d  = 7'd0;
                pc_d = 1'b1;
              end else begin
                c_d = c_q + 7'd1;
              end
            end else begin
              y_d = y_q + 7'd1;
            end
          end else begin
            mon_d = mon_q + 4'd1;
          end
        end
      end
      SET_MON: begin
        if (inc_ok) mon_d = (mon_q >= 4'd12) ? 4'd1 : mon_q + 4'd1;
      end
      SET_Y: begin
        if (inc_ok) y_d = (y_q >= Y_MAX_V) ? 7'd0 : y_q + 7'd1;
      end
      SET_C: begin
        if (inc_ok) c_d = (c_q >= C_MAX_V) ? 7'd0 : c_q + 7'd1;
      end
    endcase
  end

  // State and counter registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      mon_q   <= RST_MON_V;
      y_q     <= RST_Y_V;
      c_q     <= RST_C_V;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mon_q   <= mon_d;
      y_q     <= y_d;
      c_q     <= c_d;
      pc_q    <= pc_d;
    end
  end

  // Gregorian leap rule: divisible by 4, except century years not divisible by 400
  always_comb begin
    bus.leap = (y_q[1:0] == 2'd0) && ((y_q != 7'd0) || (c_q[1:0] == 2'd0));
  end

  // Days in the current month, fed straight from the registered counters
  always_comb begin
    bus.dim = 5'd31;
    case (mon_q)
      4'd4, 4'd6, 4'd9, 4'd11: bus.dim = 5'd30;
      4'd2:                    bus.dim = bus.leap ? 5'd29 : 5'd28;
      default:                 bus.dim = 5'd31;
    endcase
  end

  assign bus.cnt_mon   = mon_q;
  assign bus.cnt_y     = y_q;
  assign bus.cnt_c     = c_q;
  assign bus.set_state = state_q;
  assign bus.pulse_c   = pc_q;

endmodule

// File: doc/count_mon_y.md
Name: count_mon_y

Overview:
- Month/year/century counter for the century clock.
- Consumes the one-cycle month-rollover strobe `pulse_mon` produced by the day counter.
- Returns the calendar context the day counter needs: current month, year-in-century, leap flag and days-in-month.
- Owns the set-mode FSM for the month, year and century fields, driven by pre-debounced single-cycle button strobes.

Parameters:
- RST_MON, 1, month value loaded on reset (1..12)
- RST_Y, 0, year-in-century value loaded on reset (0..99)
- RST_C, 20, century value loaded on reset (0..99)
- Y_MAX, 99, last year value before wrap to 0
- C_MAX, 99, last century value before wrap to 0

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- pulse_mon  in  1  one-cycle strobe from the day counter, meaning "month ended"
- btn_mode  in  1  one-cycle debounced strobe; advances the set-mode FSM
- btn_inc  in  1  one-cycle debounced strobe; increments the field selected in set mode
- cnt_mon  out  4  current month, 1..12
- cnt_y  out  7  year within century, 0..99
- cnt_c  out  7  century, 0..99
- leap  out  1  current year is a leap year
- dim  out  5  days in the current month: 28, 29, 30 or 31
- set_state  out  2  FSM state: 0 RUN, 1 SET_MON, 2 SET_Y, 3 SET_C
- pulse_c  out  1  one-cycle strobe on century wrap C_MAX→0

Behaviour:
- Reset (async, rst_n low), effective immediately and holding while low:
  - cnt_mon=RST_MON, cnt_y=RST_Y, cnt_c=RST_C
  - set_state=RUN, pulse_c=0
- All counters and pulse_c are registered; leap and dim are combinational from the registered counters (zero added latency).
- FSM (transitions on btn_mode only):
  - RUN→SET_MON→SET_Y→SET_C→RUN
  - btn_inc never changes state.
- RUN:
  - pulse_mon=1: if cnt_mon<12, then cnt_mon+1, next cycle.
  - pulse_mon=1 with cnt_mon=12: cnt_mon=1 and cnt_y increments in the same cycle.
  - cnt_y=Y_MAX on that carry: cnt_y=0 and cnt_c increments.
  - cnt_c=C_MAX on that carry: cnt_c=0 and pulse_c=1 for exactly one cycle.
  - The whole carry chain resolves in the single cycle after pulse_mon.
  - btn_inc is ignored.
- SET_MON / SET_Y / SET_C:
  - pulse_mon is ignored and dropped, not queued; time does not advance while setting.
  - btn_inc increments only the selected field, with wrap: month 12→1, year Y_MAX→0, century C_MAX→0.
  - No carry into higher fields and no pulse_c in set mode.
- Simultaneous strobes:
  - btn_mode and btn_inc in the same cycle: the state change wins and btn_inc is dropped.
  - btn_mode and pulse_mon in the same cycle while in RUN: pulse_mon is applied using the pre-transition state (RUN), and the FSM moves to SET_MON.
- pulse_c defaults to 0 every cycle it is not explicitly asserted.
- leap = (cnt_y[1:0]==0) && (cnt_y!=0 || cnt_c[1:0]==0). This is the Gregorian century rule: 1900 is not a leap year, 2000 is.
- dim:
  - 31 for months 1,3,5,7,8,10,12
  - 30 for months 4,6,9,11
  - 29 for month 2 when leap=1, 28 for month 2 when leap=0
- Counter values outside range cannot be reached. Should one occur, the next increment still wraps to the low bound (month≥12→1, year≥Y_MAX→0, century≥C_MAX→0).
- Reset asserted mid-set clears the FSM to RUN and restores all reset values.

Test Plan:
- Reset, then idle 5 cycles → cnt_mon=1, cnt_y=0, cnt_c=20, set_state=0, leap=1, dim=31, pulse_c=0.
- From mon=2, y=23, c=20 → dim=28, leap=0. Then y=24 → dim=29. Then y=0 with c=19 → dim=28. Then y=0 with c=20 → dim=29.
- From mon=12, y=99, c=99 in RUN, one pulse_mon → next cycle mon=1, y=0, c=0, pulse_c=1 for exactly 1 cycle.
- btn_mode ×1, then btn_inc ×12 → set_state=1, mon returns to its start value. Next btn_mode, btn_inc from y=99 → y=0 with c unchanged and no pulse_c.
- In SET_Y, apply pulse_mon ×3 → no counter changes. After btn_mode ×2 → RUN, with pulse_mon counting resumed.
- Same-cycle btn_mode+btn_inc in SET_MON → set_state=2, mon unchanged. Then assert rst_n=0 mid-cycle → outputs return to reset values asynchronously.
